mcl_mbox_seq: RTL

- Sequences EBOX memory references onto the MBOX request interface, driven by the MCL request decode.
- Latches the MCL cycle type (read, write, read-pause-write, fetch, AR/ARX destination) when a cycle is requested, then runs the request/ack/response handshake.
- Generates the EBOX wait, the AR/ARX load strobes, and the page-fail and NXM-timeout events.
- Sits between MCL and the MBOX; it is the only driver of MBOX_REQ.

---
 rtl/mcl_mbox_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mcl_mbox_seq.sv
// MCL-to-MBOX reference sequencer: latches the MCL cycle type, runs the
// request/ack/response handshake and produces EBOX wait, AR/ARX strobes, page-fail and NXM.
module mcl_mbox_seq #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic RESET,
  input  logic CYC_REQ,
  input  logic VMA_READ,
  input  logic VMA_WRITE,
  input  logic VMA_PAUSE,
  input  logic LOAD_AR,
  input  logic LOAD_ARX,
  input  logic VMA_FETCH,
  input  logic PAGE_ADDRESS_COND,
  input  logic MBOX_ACK,
  input  logic MBOX_RESP,
  output logic MBOX_REQ,
  output logic MBOX_RD,
  output logic MBOX_WR,
  output logic MBOX_RPW,
  output logic MBOX_FETCH,
  output logic EBOX_WAIT,
  output logic LOAD_AR_STB,
  output logic LOAD_ARX_STB,
  output logic PF_TRAP,
  output logic NXM,
  output logic BUSY
);

  typedef enum logic [2:0] {IDLE, REQ, RD_WAIT, WR_WAIT, RPW_HOLD} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             cmd_rd;
  logic             cmd_wr;
  logic             cmd_pause;
  logic             cmd_ar;
  logic             cmd_arx;
  logic             second_word;
  logic [CNT_W-1:0] tmo_cnt;

  logic counting;
  logic tmo_hit;
  logic new_req;

  assign counting = (state == REQ) || (state == RD_WAIT) || (state == WR_WAIT);
  assign tmo_hit  = counting && (tmo_cnt == TMO_LAST);
  // A non-write request during the RPW hold is a protocol error and restarts as a fresh IDLE request.
  assign new_req  = CYC_REQ && ((state == IDLE) || ((state == RPW_HOLD) && !VMA_WRITE));

  assign EBOX_WAIT = counting || ((state == IDLE) && CYC_REQ && !PAGE_ADDRESS_COND);
  assign BUSY      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state        <= IDLE;
      cmd_rd       <= 1'b0;
      cmd_wr       <= 1'b0;
      cmd_pause    <= 1'b0;
      cmd_ar       <= 1'b0;
      cmd_arx      <= 1'b0;
      second_word  <= 1'b0;
      tmo_cnt      <= '0;
      MBOX_REQ     <= 1'b0;
      MBOX_RD      <= 1'b0;
      MBOX_WR      <= 1'b0;
      MBOX_RPW     <= 1'b0;
      MBOX_FETCH   <= 1'b0;
      LOAD_AR_STB  <= 1'b0;
      LOAD_ARX_STB <= 1'b0;
      PF_TRAP      <= 1'b0;
      NXM          <= 1'b0;
    end else begin
      LOAD_AR_STB  <= 1'b0;
      LOAD_ARX_STB <= 1'b0;
      PF_TRAP      <= 1'b0;
      NXM          <= 1'b0;

      // Saturating timeout counter; state transitions below clear it again.
      if (MBOX_RESP)
        tmo_cnt <= '0;
      else if (counting && !tmo_hit)
        tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (new_req) begin
        MBOX_RPW <= 1'b0;
        tmo_cnt  <= '0;
        if (PAGE_ADDRESS_COND) begin
          PF_TRAP <= 1'b1;
          state   <= IDLE;
        end else begin
          cmd_rd      <= VMA_READ;
          cmd_wr      <= VMA_WRITE;
          cmd_pause   <= VMA_PAUSE;
          cmd_ar      <= LOAD_AR;
          cmd_arx     <= LOAD_ARX;
          second_word <= 1'b0;
          MBOX_REQ    <= 1'b1;
          MBOX_RD     <= VMA_READ;
          MBOX_WR     <= VMA_WRITE && !VMA_READ;
          MBOX_FETCH  <= VMA_FETCH;
          state       <= REQ;
        end
      end else begin
        case (state)
          REQ: begin
            if (MBOX_ACK) begin
              MBOX_REQ   <= 1'b0;
              MBOX_RD    <= 1'b0;
              MBOX_WR    <= 1'b0;
              MBOX_FETCH <= 1'b0;
              tmo_cnt    <= '0;
              state      <= cmd_rd ? RD_WAIT : WR_WAIT;
            end else if (tmo_hit) begin
              MBOX_REQ   <= 1'b0;
              MBOX_RD    <= 1'b0;
              MBOX_WR    <= 1'b0;
              MBOX_FETCH <= 1'b0;
              MBOX_RPW   <= 1'b0;
              NXM        <= 1'b1;
              tmo_cnt    <= '0;
              state      <= IDLE;
            end
          end
          RD_WAIT: begin
            if (MBOX_RESP) begin
              if (!second_word && cmd_ar)
                LOAD_AR_STB <= 1'b1;
              else
                LOAD_ARX_STB <= 1'b1;
              // An RW cycle also parks in the hold so the write half can follow.
              if (cmd_ar && cmd_arx && !second_word) begin
                second_word <= 1'b1;
              end else begin
                MBOX_RPW <= cmd_pause || cmd_wr;
                state    <= (cmd_pause || cmd_wr) ? RPW_HOLD : IDLE;
              end
            end else if (tmo_hit) begin
              MBOX_RPW <= 1'b0;
              NXM      <= 1'b1;
              tmo_cnt  <= '0;
              state    <= IDLE;
            end
          end
          WR_WAIT: begin
            if (MBOX_RESP) begin
              MBOX_RPW <= 1'b0;
              state    <= IDLE;
            end else if (tmo_hit) begin
              MBOX_RPW <= 1'b0;
              NXM      <= 1'b1;
              tmo_cnt  <= '0;
              state    <= IDLE;
            end
          end
          RPW_HOLD: begin
            if (CYC_REQ) begin
              cmd_rd      <= 1'b0;
              cmd_wr      <= 1'b1;
              cmd_pause   <= 1'b0;
              cmd_ar      <= 1'b0;
              cmd_arx     <= 1'b0;
              second_word <= 1'b0;
              MBOX_REQ    <= 1'b1;
              MBOX_RD     <= 1'b0;
              MBOX_WR     <= 1'b1;
              MBOX_FETCH  <= 1'b0;
              tmo_cnt     <= '0;
              state       <= REQ;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
